fetch_ctrl: RTL

Sequencing controller for the PC-holding fetch unit. Owns the instruction-memory request handshake, decides each cycle whether the PC loads a new target, holds, or increments by 4, and buffers one fetched instruction for decode. Sits between the fetch unit, instruction memory, execute-stage redirect logic and decode. Allows at most one outstanding memory request.

---
 rtl/fetch_ctrl_if.sv | 73 +++++++
 rtl/fetch_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Bundles the fetch-unit, instruction-memory, redirect and decode signals
// of fetch_ctrl. The trap redirect pair exists only when FETCH_CTRL_TRAP_EN
// is defined.
interface fetch_ctrl_if;
    logic [31:0] io_pc;
    logic        io_br_valid;
    logic [31:0] io_br_target;
`ifdef FETCH_CTRL_TRAP_EN
    logic        io_trap_valid;
    logic [31:0] io_trap_vector;
`endif
    logic [31:0] io_npc;
    logic        io_ctrl_0;
    logic        io_ctrl_1;
    logic        io_imem_req;
    logic [31:0] io_imem_addr;
    logic        io_imem_gnt;
    logic        io_imem_rvalid;
    logic [31:0] io_imem_rdata;
    logic        io_inst_valid;
    logic [31:0] io_inst;
    logic [31:0] io_inst_pc;
    logic        io_dec_ready;
    logic        io_flush;

    // Controller view
    modport master (
`ifdef FETCH_CTRL_TRAP_EN
        input  io_trap_valid,
        input  io_trap_vector,
`endif
        input  io_pc,
        input  io_br_valid,
        input  io_br_target,
        input  io_imem_gnt,
        input  io_imem_rvalid,
        input  io_imem_rdata,
        input  io_dec_ready,
        output io_npc,
        output io_ctrl_0,
        output io_ctrl_1,
        output io_imem_req,
        output io_imem_addr,
        output io_inst_valid,
        output io_inst,
        output io_inst_pc,
        output io_flush
    );

    // Environment view (fetch unit, memory, execute, decode)
    modport slave (
`ifdef FETCH_CTRL_TRAP_EN
        output io_trap_valid,
        output io_trap_vector,
`endif
        output io_pc,
        output io_br_valid,
        output io_br_target,
        output io_imem_gnt,
        output io_imem_rvalid,
        output io_imem_rdata,
        output io_dec_ready,
        input  io_npc,
        input  io_ctrl_0,
        input  io_ctrl_1,
        input  io_imem_req,
        input  io_imem_addr,
        input  io_inst_valid,
        input  io_inst,
        input  io_inst_pc,
        input  io_flush
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: sequences the PC-holding fetch unit, owns the single
// outstanding instruction-memory request and buffers one instruction for
// decode. Defining FETCH_CTRL_TRAP_EN adds a trap redirect that outranks
// a simultaneous branch.
module fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset_n,
    fetch_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        DRAIN,
        DELIVER
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_grant;
    logic        r_instValid;
    logic [31:0] r_inst;
    logic [31:0] r_instPc;

`ifdef FETCH_CTRL_TRAP_EN
    assign w_redirect = (r_state != BOOT) && (bus.io_trap_valid || bus.io_br_valid);
    assign w_target   = bus.io_trap_valid ? bus.io_trap_vector : bus.io_br_target;
`else
    assign w_redirect = (r_state != BOOT) && bus.io_br_valid;
    assign w_target   = bus.io_br_target;
`endif

    assign w_grant = (r_state == REQ) && bus.io_imem_gnt;

    // State register; reset aborts any transaction and restarts from BOOT
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state; a granted request whose response is no longer wanted drains
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BOOT: begin
                w_nextState = REQ;
            end
            REQ: begin
                if (bus.io_imem_gnt) begin
                    w_nextState = w_redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (w_redirect) begin
                    w_nextState = bus.io_imem_rvalid ? REQ : DRAIN;
                end else if (bus.io_imem_rvalid) begin
                    w_nextState = DELIVER;
                end
            end
            DRAIN: begin
                if (bus.io_imem_rvalid) begin
                    w_nextState = REQ;
                end
            end
            DELIVER: begin
                if (w_redirect || bus.io_dec_ready) begin
                    w_nextState = REQ;
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // Combinational fetch-unit and memory controls; redirect overrides hold/increment
    always_comb begin
        bus.io_ctrl_0    = 1'b0;
        bus.io_ctrl_1    = 1'b1;
        bus.io_npc       = bus.io_br_target;
        bus.io_imem_req  = 1'b0;
        bus.io_imem_addr = bus.io_pc;
        bus.io_flush     = 1'b0;
        case (r_state)
            BOOT: begin
                bus.io_ctrl_0 = 1'b1;
                bus.io_ctrl_1 = 1'b0;
                bus.io_npc    = BOOT_ADDR;
            end
            REQ: begin
                bus.io_imem_req = 1'b1;
                if (w_grant && !w_redirect) begin
                    bus.io_ctrl_1 = 1'b0;
                end
            end
            default: begin
            end
        endcase
        if (w_redirect) begin
            bus.io_ctrl_0 = 1'b1;
            bus.io_ctrl_1 = 1'b0;
            bus.io_npc    = w_target;
            bus.io_flush  = 1'b1;
        end
    end

    // Instruction buffer: tag on grant, capture on response, release on decode accept
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instValid <= 1'b0;
            r_inst      <= 32'h0;
            r_instPc    <= 32'h0;
        end else if (w_redirect) begin
            r_instValid <= 1'b0;
        end else begin
            case (r_state)
                REQ: begin
                    if (bus.io_imem_gnt) begin
                        r_instPc <= bus.io_pc;
                    end
                end
                WAIT: begin
                    if (bus.io_imem_rvalid) begin
                        r_inst      <= bus.io_imem_rdata;
                        r_instValid <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (bus.io_dec_ready) begin
                        r_instValid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.io_inst_valid = r_instValid;
    assign bus.io_inst       = r_inst;
    assign bus.io_inst_pc    = r_instPc;

endmodule
